box_motion_ctrl: RTL and testbench

Per-frame position controller for the on-screen box sprite in the VGA display path. Once per frame, on the timing generator's `screenEnd` pulse, it runs a short update sequence: it samples either the debounced push-buttons or the accelerometer, computes a signed step, clamps the box to the visible area and commits new top-left coordinates. The VGA controller's box-drawing comparator consumes these coordinates in place of its own per-frame latch.

---
 rtl/box_motion_ctrl_pkg.sv | 59 +++++
 rtl/box_motion_ctrl_if.sv | 27 ++
 rtl/box_motion_ctrl_btn_debouncer.sv | 42 ++++
 rtl/box_motion_ctrl.sv | 135 +++++++++++++
 tb/tb_box_motion_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/box_motion_ctrl_pkg.sv
// Shared types, screen geometry defaults and arithmetic helpers for the box sprite
// position controller.
package box_ctrl_pkg;

    localparam int SCREEN_W_DEF        = 640;
    localparam int SCREEN_H_DEF        = 480;
    localparam int BOX_SIZE_DEF        = 50;
    localparam int STEP_DEF            = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int DEADZONE_DEF        = 16;
    localparam int ACCEL_SHIFT_DEF     = 3;
    localparam int ACCEL_CENTER        = 256;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_STEP,
        ST_CLAMP,
        ST_COMMIT
    } state_e;

    function automatic int center_pos(input int screen, input int box);
        return (screen - box) / 2;
    endfunction

    localparam int RESET_X = center_pos(SCREEN_W_DEF, BOX_SIZE_DEF);
    localparam int RESET_Y = center_pos(SCREEN_H_DEF, BOX_SIZE_DEF);

    // Raw reading to signed pixels/frame; the offset range of -256..255 lands in -32..31.
    function automatic logic signed [6:0] accel_step(input logic [8:0] raw,
                                                     input int deadzone,
                                                     input int shift);
        logic signed [9:0] o;
        logic signed [9:0] dz;
        o  = $signed({1'b0, raw}) - $signed(10'(ACCEL_CENTER));
        dz = 10'(deadzone);
        if (o > dz || o < -dz) begin
            return 7'(o >>> shift);
        end
        return '0;
    endfunction

    function automatic logic signed [11:0] clamp_pos(input logic signed [11:0] v,
                                                     input logic signed [11:0] hi);
        if (v < 0) begin
            return '0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/box_motion_ctrl_if.sv
// Frame trigger, user inputs and committed box coordinates of the motion controller.
interface box_motion_ctrl_if;

    logic       screen_end;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [8:0] accel_x;
    logic [8:0] accel_y;
    logic       mode;
    logic [9:0] tl_x;
    logic [9:0] tl_y;
    logic       update_done;
    logic       busy;

    modport master (
        output screen_end, btn_up, btn_down, btn_left, btn_right, accel_x, accel_y, mode,
        input  tl_x, tl_y, update_done, busy
    );

    modport slave (
        input  screen_end, btn_up, btn_down, btn_left, btn_right, accel_x, accel_y, mode,
        output tl_x, tl_y, update_done, busy
    );

endinterface

// File: rtl/box_motion_ctrl_btn_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the accepted level flips
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_25mHz,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box sprite position update: sample buttons or accelerometer on the
// screen_end rise, step, clamp to the visible area and commit new coordinates.
//
// state     | meaning
// ST_IDLE   | waiting for a screen_end rising edge
// ST_SAMPLE | compute signed dx/dy from current mode and inputs
// ST_STEP   | add step to current coordinates at 12-bit signed width
// ST_CLAMP  | limit result to 0..(screen - box)
// ST_COMMIT | load tl_x/tl_y and pulse update_done
module box_motion_ctrl
    import box_ctrl_pkg::*;
#(
    parameter int SCREEN_W        = SCREEN_W_DEF,
    parameter int SCREEN_H        = SCREEN_H_DEF,
    parameter int BOX_SIZE        = BOX_SIZE_DEF,
    parameter int STEP            = STEP_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DEADZONE        = DEADZONE_DEF,
    parameter int ACCEL_SHIFT     = ACCEL_SHIFT_DEF
) (
    input  logic              clk_25mHz,
    input  logic              reset,
    box_motion_ctrl_if.slave  bus
);

    localparam logic        [9:0]  RST_X  = 10'(center_pos(SCREEN_W, BOX_SIZE));
    localparam logic        [9:0]  RST_Y  = 10'(center_pos(SCREEN_H, BOX_SIZE));
    localparam logic signed [11:0] MAX_X  = 12'(SCREEN_W - BOX_SIZE);
    localparam logic signed [11:0] MAX_Y  = 12'(SCREEN_H - BOX_SIZE);
    localparam logic signed [6:0]  STEP_P = 7'(STEP);

    state_e             state_q, state_d;
    logic               screen_end_q;
    logic               trig;
    logic [3:0]         btn_raw;
    logic [3:0]         btn_db;
    logic signed [6:0]  step_dx, step_dy;
    logic signed [6:0]  dx_q, dy_q;
    logic signed [11:0] nx_q, ny_q;
    logic [9:0]         cx_q, cy_q;
    logic [9:0]         tl_x_q, tl_y_q;
    logic               update_done_q;

    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_25mHz (clk_25mHz),
            .reset     (reset),
            .btn_i     (btn_raw[i]),
            .level_o   (btn_db[i])
        );
    end

    assign trig = bus.screen_end & ~screen_end_q;

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // COMMIT may accept a fresh trigger since update_done is already registered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (trig) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_STEP;
            ST_STEP:   state_d = ST_CLAMP;
            ST_CLAMP:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = trig ? ST_SAMPLE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_dx = '0;
        step_dy = '0;
        if (bus.mode) begin
            step_dx = accel_step(bus.accel_y, DEADZONE, ACCEL_SHIFT);
            step_dy = accel_step(bus.accel_x, DEADZONE, ACCEL_SHIFT);
        end else begin
            if (btn_db[BTN_RIGHT] && !btn_db[BTN_LEFT]) step_dx = STEP_P;
            else if (btn_db[BTN_LEFT] && !btn_db[BTN_RIGHT]) step_dx = -STEP_P;
            if (btn_db[BTN_DOWN] && !btn_db[BTN_UP]) step_dy = STEP_P;
            else if (btn_db[BTN_UP] && !btn_db[BTN_DOWN]) step_dy = -STEP_P;
        end
    end

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            screen_end_q  <= 1'b0;
            dx_q          <= '0;
            dy_q          <= '0;
            nx_q          <= '0;
            ny_q          <= '0;
            cx_q          <= RST_X;
            cy_q          <= RST_Y;
            tl_x_q        <= RST_X;
            tl_y_q        <= RST_Y;
            update_done_q <= 1'b0;
        end else begin
            screen_end_q  <= bus.screen_end;
            update_done_q <= 1'b0;
            case (state_q)
                ST_SAMPLE: begin
                    dx_q <= step_dx;
                    dy_q <= step_dy;
                end
                ST_STEP: begin
                    nx_q <= $signed({2'b00, tl_x_q}) + {{5{dx_q[6]}}, dx_q};
                    ny_q <= $signed({2'b00, tl_y_q}) + {{5{dy_q[6]}}, dy_q};
                end
                ST_CLAMP: begin
                    cx_q <= 10'(clamp_pos(nx_q, MAX_X));
                    cy_q <= 10'(clamp_pos(ny_q, MAX_Y));
                end
                ST_COMMIT: begin
                    tl_x_q        <= cx_q;
                    tl_y_q        <= cy_q;
                    update_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tl_x        = tl_x_q;
    assign bus.tl_y        = tl_y_q;
    assign bus.update_done = update_done_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Randomized and directed frames against an arithmetic position model of the box controller.
module tb_box_motion_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ref_x, ref_y;

    always #20 clk = ~clk;

    box_motion_ctrl_if bus ();

    box_motion_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_25mHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int btn_step(input bit pos, input bit neg);
        return (pos ? 4 : 0) - (neg ? 4 : 0);
    endfunction

    function automatic int acc_step(input int raw);
        int o;
        o = raw - 256;
        if (o <= 16 && o >= -16) return 0;
        if (o >= 0) return o / 8;
        return -((-o + 7) / 8);
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic set_inputs(input bit md, input bit up, input bit dn, input bit lf,
                              input bit rt, input int ax, input int ay);
        bus.mode      = md;
        bus.btn_up    = up;
        bus.btn_down  = dn;
        bus.btn_left  = lf;
        bus.btn_right = rt;
        bus.accel_x   = 9'(ax);
        bus.accel_y   = 9'(ay);
    endtask

    task automatic run_frame(input int settle, input bit retrig);
        int dx, dy, ex, ey, px, py;
        px = ref_x;
        py = ref_y;
        repeat (settle) @(negedge clk);
        if (bus.mode) begin
            dx = acc_step(int'(bus.accel_y));
            dy = acc_step(int'(bus.accel_x));
        end else begin
            dx = btn_step(bus.btn_right, bus.btn_left);
            dy = btn_step(bus.btn_down, bus.btn_up);
        end
        ex = clampi(px + dx, 590);
        ey = clampi(py + dy, 430);
        @(negedge clk);
        bus.screen_end = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) bus.screen_end = 1'b0;
            if (retrig && e == 1) bus.screen_end = 1'b1;
            if (retrig && e == 2) bus.screen_end = 1'b0;
            if (e < 4) begin
                check_val("busy_in_flight", 32'(bus.busy), 1);
                check_val("done_early", 32'(bus.update_done), 0);
                check_val("x_hold", 32'(bus.tl_x), 32'(px));
                check_val("y_hold", 32'(bus.tl_y), 32'(py));
            end else if (e == 4) begin
                check_val("busy_end", 32'(bus.busy), 0);
                check_val("done_pulse", 32'(bus.update_done), 1);
                check_val("x_commit", 32'(bus.tl_x), 32'(ex));
                check_val("y_commit", 32'(bus.tl_y), 32'(ey));
            end else begin
                check_val("done_one_cycle", 32'(bus.update_done), 0);
                check_val("no_extra_update", 32'(bus.busy), 0);
            end
        end
        ref_x = ex;
        ref_y = ey;
    endtask

    task automatic reset_mid_update();
        @(negedge clk);
        bus.screen_end = 1'b1;
        @(posedge clk);
        #1 bus.screen_end = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_busy", 32'(bus.busy), 0);
        check_val("rst_mid_x", 32'(bus.tl_x), 295);
        check_val("rst_mid_y", 32'(bus.tl_y), 215);
        check_val("rst_mid_done", 32'(bus.update_done), 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check_val("rst_mid_no_done", 32'(bus.update_done), 0);
        end
        ref_x = 295;
        ref_y = 215;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.screen_end = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 256, 256);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_x", 32'(bus.tl_x), 295);
        check_val("rst_y", 32'(bus.tl_y), 215);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_done", 32'(bus.update_done), 0);
        @(negedge clk) reset = 1'b0;
        ref_x = 295;
        ref_y = 215;

        set_inputs(0, 0, 0, 0, 1, 256, 256);
        run_frame(8, 0);
        check_val("step_right_x", 32'(bus.tl_x), 299);

        set_inputs(0, 1, 0, 1, 0, 256, 256);
        run_frame(8, 0);
        for (int f = 0; f < 79; f++) run_frame(2, 0);
        check_val("clamp_low_x", 32'(bus.tl_x), 0);
        check_val("clamp_low_y", 32'(bus.tl_y), 0);

        set_inputs(0, 0, 1, 0, 1, 256, 256);
        run_frame(8, 0);
        for (int f = 0; f < 159; f++) run_frame(2, 0);
        check_val("clamp_high_x", 32'(bus.tl_x), 590);
        check_val("clamp_high_y", 32'(bus.tl_y), 430);

        ref_x = ref_x; // continue from clamped corner
        set_inputs(0, 0, 0, 1, 0, 256, 256);
        for (int f = 0; f < 20; f++) run_frame(8, 0);

        set_inputs(1, 0, 0, 0, 0, 266, 356);
        for (int f = 0; f < 3; f++) run_frame(4, 0);
        set_inputs(1, 0, 0, 0, 0, 266, 0);
        for (int f = 0; f < 3; f++) run_frame(4, 0);

        set_inputs(0, 0, 0, 0, 0, 256, 256);
        run_frame(8, 0);
        for (int i = 0; i < 20; i++) begin
            bus.btn_down = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        bus.btn_down = 1'b0;
        run_frame(0, 0);
        run_frame(8, 1);

        for (int f = 0; f < 40; f++) begin
            set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 511)));
            run_frame(8, f % 5 == 0);
        end

        set_inputs(0, 0, 0, 1, 0, 256, 256);
        run_frame(8, 0);
        reset_mid_update();
        set_inputs(0, 0, 1, 0, 0, 256, 256);
        run_frame(8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
